// File: rtl/cim_pkg.sv
// Constants and lane helper shared by the CIM Core and its PSUM accumulator.
package cim_pkg;
    localparam int PSUM_W  = 14;
    localparam int N_CH    = 8;
    localparam int N_MACRO = 9;
    localparam int N_COL   = 3;
    localparam int N_ROW   = N_MACRO / N_COL;
    localparam int SLICE_W = N_CH * PSUM_W;
    localparam int BUS_W   = N_MACRO * SLICE_W;
    localparam int SUM_W   = 18;
    localparam int ACC_W   = 24;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 4;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    // Lane j of macro k on the PSUM bus.
    function automatic logic [PSUM_W-1:0] psum_lane(input logic [BUS_W-1:0] bus,
                                                   input int unsigned k,
                                                   input int unsigned j);
        return bus[k*SLICE_W + j*PSUM_W +: PSUM_W];
    endfunction
endpackage

// File: rtl/psum_accumulator_sum9.sv
// One output channel: sign-extends the nine macro partial sums and registers their total.
module psum_sum9
    import cim_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MACRO*PSUM_W-1:0] lanes_i,
    output logic signed [SUM_W-1:0] sum_o
);
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_MACRO; k++) begin
            sum_d = sum_d + SUM_W'(signed'(lanes_i[k*PSUM_W +: PSUM_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/psum_accumulator.sv
// Deskews the Core PSUM columns, sums the 9 macros per channel, accumulates across
// input-channel tiles and emits ReLU/shift/saturated activations through a valid/ready register.
module psum_accumulator
    import cim_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [BUS_W-1:0]       psum_in,
    input  logic [SHIFT_W-1:0]     shift_amt,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [N_CH*OUT_W-1:0]  out_data,
    output logic                   ovf_flag,
    output logic                   busy
);
    function automatic logic [OUT_W-1:0] relu_shift_sat(input logic signed [ACC_W-1:0] a,
                                                        input logic [SHIFT_W-1:0] sh);
        logic [ACC_W-1:0] s;
        s = $unsigned(a) >> sh;
        if (a[ACC_W-1]) return '0;
        if (|s[ACC_W-1:OUT_W]) return '1;
        return s[OUT_W-1:0];
    endfunction

    logic [N_ROW-1:0][SLICE_W-1:0] col0_dly1_q;
    logic [N_ROW-1:0][SLICE_W-1:0] col0_dly2_q;
    logic [N_ROW-1:0][SLICE_W-1:0] col1_dly_q;
    logic [BUS_W-1:0]              aligned_bus;

    tag_t tag1_q, tag2_q, tag3_q;

    logic signed [SUM_W-1:0] sum_r [N_CH];
    logic signed [ACC_W-1:0] acc_q [N_CH];
    logic signed [ACC_W-1:0] acc_next [N_CH];
    logic signed [ACC_W-1:0] acc_d [N_CH];

    logic                  load;
    logic                  out_valid_q, out_valid_d;
    logic [N_CH*OUT_W-1:0] out_data_q, out_data_d;
    logic                  ovf_q, ovf_d;

    // Stage T / T+1: column 0 is delayed two cycles and column 1 one cycle so all three line up at T+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            col0_dly1_q <= '0;
            col0_dly2_q <= '0;
            col1_dly_q  <= '0;
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                col0_dly1_q[r] <= psum_in[(r*N_COL + 0)*SLICE_W +: SLICE_W];
                col1_dly_q[r]  <= psum_in[(r*N_COL + 1)*SLICE_W +: SLICE_W];
            end
            col0_dly2_q <= col0_dly1_q;
        end
    end

    always_comb begin
        aligned_bus = '0;
        for (int r = 0; r < N_ROW; r++) begin
            aligned_bus[(r*N_COL + 0)*SLICE_W +: SLICE_W] = col0_dly2_q[r];
            aligned_bus[(r*N_COL + 1)*SLICE_W +: SLICE_W] = col1_dly_q[r];
            aligned_bus[(r*N_COL + 2)*SLICE_W +: SLICE_W] = psum_in[(r*N_COL + 2)*SLICE_W +: SLICE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            tag1_q <= '{vld: in_valid, first: in_first, last: in_last};
            tag2_q <= tag1_q;
            tag3_q <= tag2_q;
        end
    end

    // Stage T+2: nine-way sum per channel, registered inside the sub-module.
    for (genvar j = 0; j < N_CH; j++) begin : g_ch
        logic [N_MACRO*PSUM_W-1:0] lanes;

        always_comb begin
            lanes = '0;
            for (int k = 0; k < N_MACRO; k++) begin
                lanes[k*PSUM_W +: PSUM_W] = psum_lane(aligned_bus, k, j);
            end
        end

        psum_sum9 u_sum9 (
            .clk     (clk),
            .rst     (rst),
            .lanes_i (lanes),
            .sum_o   (sum_r[j])
        );
    end

    // Stage T+3: accumulate and, on the last tile, load the output register.
    always_comb begin
        load        = tag3_q.vld & tag3_q.last;
        out_data_d  = out_data_q;
        for (int j = 0; j < N_CH; j++) begin
            acc_next[j] = tag3_q.first ? ACC_W'(sum_r[j]) : acc_q[j] + ACC_W'(sum_r[j]);
            acc_d[j]    = tag3_q.vld ? acc_next[j] : acc_q[j];
            if (load) begin
                out_data_d[j*OUT_W +: OUT_W] = relu_shift_sat(acc_next[j], shift_amt);
            end
        end
        out_valid_d = load | (out_valid_q & ~out_ready);
        ovf_d       = ovf_q | (load & out_valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_CH; j++) begin
                acc_q[j] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            for (int j = 0; j < N_CH; j++) begin
                acc_q[j] <= acc_d[j];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf_flag  = ovf_q;
    assign busy      = in_valid | tag1_q.vld | tag2_q.vld | tag3_q.vld;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised and directed bench for psum_accumulator with a cycle-indexed reference model.
module tb_psum_accumulator;
    import cim_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [BUS_W-1:0]      psum_in;
    logic [SHIFT_W-1:0]    shift_amt;
    logic                  out_ready;
    logic                  out_valid;
    logic [N_CH*OUT_W-1:0] out_data;
    logic                  ovf_flag;
    logic                  busy;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .psum_in   (psum_in),
        .shift_amt (shift_amt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ovf_flag  (ovf_flag),
        .busy      (busy)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    // History of what was presented at each clock edge.
    bit [BUS_W-1:0] bus_h [4096];
    bit             vld_h [4096];
    bit             fst_h [4096];
    bit             lst_h [4096];

    bit                  m_valid;
    bit [N_CH*OUT_W-1:0] m_data;
    bit                  m_ovf;
    longint              m_acc [N_CH];

    function automatic logic [BUS_W-1:0] pat(input int v, input int kmask);
        logic [BUS_W-1:0]  b;
        logic [PSUM_W-1:0] l;
        b = '0;
        l = PSUM_W'(v);
        for (int k = 0; k < N_MACRO; k++)
            if (kmask[k])
                for (int j = 0; j < N_CH; j++) b[k*SLICE_W + j*PSUM_W +: PSUM_W] = l;
        return b;
    endfunction

    function automatic longint wrap24(input longint x);
        longint y;
        y = x & 64'hFFFFFF;
        if (y >= 64'h800000) y = y - 64'h1000000;
        return y;
    endfunction

    function automatic bit vld_at(input int t);
        return (t >= 0) ? vld_h[t] : 1'b0;
    endfunction

    function automatic bit exp_busy();
        return in_valid | vld_at(cyc-1) | vld_at(cyc-2) | vld_at(cyc-3);
    endfunction

    // Vector presented at edge T is summed from the bus at T, T+1, T+2 (by column) and lands at edge T+3.
    task automatic model_edge(input int e, input bit r, input bit rdy, input int sh);
        bit                  ld;
        bit [N_CH*OUT_W-1:0] nd;
        logic signed [PSUM_W-1:0] lane;
        longint s, v;
        int t;
        ld = 1'b0;
        nd = '0;
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            for (int j = 0; j < N_CH; j++) m_acc[j] = 0;
            for (int i = e - 3; i <= e; i++) if (i >= 0) vld_h[i] = 1'b0;
            return;
        end
        if (e >= 3 && vld_h[e-3]) begin
            t = e - 3;
            for (int j = 0; j < N_CH; j++) begin
                s = 0;
                for (int k = 0; k < N_MACRO; k++) begin
                    lane = bus_h[t + k % N_COL][k*SLICE_W + j*PSUM_W +: PSUM_W];
                    s = s + longint'(lane);
                end
                m_acc[j] = wrap24(fst_h[t] ? s : m_acc[j] + s);
                v = (m_acc[j] < 0) ? 0 : (m_acc[j] >>> sh);
                if (v > 255) v = 255;
                nd[j*OUT_W +: OUT_W] = OUT_W'(v);
            end
            ld = lst_h[t];
        end
        if (ld) begin
            if (m_valid && !rdy) m_ovf = 1'b1;
            m_valid = 1'b1;
            m_data  = nd;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        int e;
        bit r, rdy;
        int sh;
        e = cyc;
        bus_h[e] = psum_in;
        vld_h[e] = in_valid;
        fst_h[e] = in_first;
        lst_h[e] = in_last;
        r   = rst;
        rdy = out_ready;
        sh  = int'(shift_amt);
        @(posedge clk);
        #1;
        model_edge(e, r, rdy, sh);
        cyc++;
    endtask

    task automatic send_vec(input logic [BUS_W-1:0] b, input bit f, input bit l);
        psum_in  = b;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        psum_in = '0; shift_amt = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        shift_amt = 4'd0;
        psum_in = pat(10, 9'h1FF);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick();
        tick();
        psum_in = '0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        for (int j = 0; j < N_CH; j++) begin
            checks++;
            if (out_data[j*OUT_W +: OUT_W] !== 8'd90) begin
                errs++; $display("FAIL single_ch%0d: got %0d expected 90", j, out_data[j*OUT_W +: OUT_W]);
            end
        end
        consume();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_consume: got %b expected 0", out_valid); end
    endtask

    task automatic test_skew();
        psum_in = pat(1, 9'h049);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        psum_in = pat(2, 9'h092);
        tick();
        psum_in = pat(4, 9'h124);
        tick();
        psum_in = '0;
        tick();
        for (int j = 0; j < N_CH; j++) begin
            checks++;
            if (out_data[j*OUT_W +: OUT_W] !== 8'd21) begin
                errs++; $display("FAIL skew_ch%0d: got %0d expected 21", j, out_data[j*OUT_W +: OUT_W]);
            end
        end
        consume();
    endtask

    task automatic test_relu_sat();
        send_vec(pat(-5, 9'h1FF), 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL relu_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== '0) begin errs++; $display("FAIL relu_data: got %h expected 0", out_data); end
        consume();
        send_vec(pat(8191, 9'h1FF), 1'b1, 1'b1);
        checks++; if (out_data !== {N_CH{8'hFF}}) begin errs++; $display("FAIL sat_data: got %h expected all ff", out_data); end
        consume();
    endtask

    task automatic test_back_to_back();
        shift_amt = 4'd4;
        psum_in = pat(100, 9'h1FF);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_first = (i == 0); in_last = (i == 3);
            tick();
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_early_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== {N_CH{8'd225}}) begin errs++; $display("FAIL b2b_data: got %h expected all e1", out_data); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle: got %b expected 0", busy); end
        consume();
        tick();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_single_pulse: got %b expected 0", out_valid); end
        shift_amt = 4'd0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_vec(pat(10, 9'h001), 1'b1, 1'b1);
        checks++; if (out_data !== {N_CH{8'd10}}) begin errs++; $display("FAIL ovf_first_data: got %h expected all 0a", out_data); end
        checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL ovf_early: got %b expected 0", ovf_flag); end
        send_vec(pat(20, 9'h001), 1'b1, 1'b1);
        checks++; if (out_data !== {N_CH{8'd20}}) begin errs++; $display("FAIL ovf_data: got %h expected all 14", out_data); end
        checks++; if (ovf_flag !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b expected 1", ovf_flag); end
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL ovf_valid_held: got %b expected 1", out_valid); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ovf_consume: got %b expected 0", out_valid); end
        checks++; if (ovf_flag !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b expected 1", ovf_flag); end
    endtask

    task automatic test_midreset();
        psum_in = pat(10, 9'h1FF);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (ovf_flag !== 1'b0) begin errs++; $display("FAIL midrst_ovf: got %b expected 0", ovf_flag); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_no_result: got %b expected 0", out_valid); end
        send_vec(pat(10, 9'h1FF), 1'b0, 1'b1);
        checks++; if (out_data !== {N_CH{8'd90}}) begin errs++; $display("FAIL midrst_acc_cleared: got %h expected all 5a", out_data); end
        consume();
    endtask

    task automatic test_random(input int n, input int sh);
        shift_amt = SHIFT_W'(sh);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < N_MACRO*N_CH; l++) begin
                if ($urandom_range(0, 3) == 0) psum_in[l*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
                else psum_in[l*PSUM_W +: PSUM_W] = PSUM_W'($urandom_range(0, 600));
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 2) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            rst       = ($urandom_range(0, 199) == 0);
            tick();
            checks++; if (out_valid !== m_valid) begin errs++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid, m_valid); end
            checks++; if (out_data !== m_data) begin errs++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, out_data, m_data); end
            checks++; if (ovf_flag !== m_ovf) begin errs++; $display("FAIL rand_ovf@%0d: got %b expected %b", cyc, ovf_flag, m_ovf); end
            checks++; if (busy !== exp_busy()) begin errs++; $display("FAIL rand_busy@%0d: got %b expected %b", cyc, busy, exp_busy()); end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_skew();
        test_relu_sat();
        test_back_to_back();
        test_overflow();
        test_midreset();
        test_random(700, 0);
        test_random(700, int'($urandom_range(1, 9)));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the 3x3 CIM Core and consumes its 1008-bit PSUM bus (9 macros x 8 channels x 14b).
- Aligns the 1- and 2-cycle horizontal pipeline skew between macro columns.
- Sums the 9 macro partial sums per output channel and accumulates across input-channel tiles.
- On the final tile, applies ReLU, right-shift and unsigned saturation, then presents 8 output activations through a valid/ready register.

Parameters:
PSUM_W, 14, width of one macro partial sum (signed two's complement)
N_CH, 8, output channels per macro
ACC_W, 24, accumulator width per channel (signed)
OUT_W, 8, output activation width (unsigned)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  activation vector entered Core column 0 this cycle
in_first  in  1  tag with in_valid: start a new accumulation
in_last  in  1  tag with in_valid: final tile, emit result
psum_in  in  1008  Core PSUM; slice k (0..8) = bits [k*112 +: 112], col = k%3, row = k/3; channel j = [k*112 + j*14 +: 14]
shift_amt  in  4  output right-shift; held static while busy
out_ready  in  1  consumer accepts out_data
out_valid  out  1  out_data holds a result
out_data  out  64  8 x OUT_W; channel j at [j*8 +: 8]
ovf_flag  out  1  sticky: unconsumed result was overwritten
busy  out  1  any tagged vector in flight

Behaviour:
- Reset values: out_valid=0, out_data=0, ovf_flag=0, busy=0. Reset also clears the tag pipe, column delay registers, sum registers and all accumulators.
- Reset at any cycle drops in-flight vectors; no out_valid results from them.
- Vector accepted at cycle T (in_valid=1), with its tags, is processed in these stages:
  - T: sample column-0 slices (k=0,3,6) into a 2-deep delay.
  - T+1: sample column-1 slices (k=1,4,7) into a 1-deep delay.
  - T+2: column-2 slices (k=2,5,8) taken live from psum_in. Per channel, sign-extend all 9 values and sum (18b result, sign-extended to ACC_W). Register as sum_r, valid in T+3.
  - T+3: acc_next = tag_first ? sum_r : acc + sum_r. Register acc_next. Addition wraps modulo 2^ACC_W; no overflow detection.
- psum_in is sampled at T+1 and T+2 regardless of in_valid in those cycles.
- Back-to-back in_valid every cycle is supported, throughput 1 vector/cycle.
- When tag_last is set at T+3, the output register loads at the end of T+3; out_valid=1 from T+4 (latency 4). Per channel:
  - negative acc_next -> 0
  - else acc_next >> shift_amt, truncating
  - values > 2^OUT_W-1 saturate to 255
- in_first=in_last=1: single-tile result.
- in_last without a preceding in_first: result accumulates onto the existing acc.
- in_first while an accumulation is open: the old partial is discarded silently.
- Output handshake:
  - out_valid holds, and out_data stays stable, until out_valid && out_ready.
  - If a new result loads in a cycle where out_valid=1 and out_ready=0: new data overwrites and ovf_flag sets. ovf_flag clears only on rst.
  - out_ready=1 in the same cycle as a load: old result consumed, new result loaded, out_valid stays 1, no overflow.
- busy = OR of in_valid and the valid bits of the stage T+1..T+3 tag pipe.

Decomposition:
- Shared package cim_pkg holds PSUM_W, N_CH, N_MACRO=9, N_COL=3, SLICE_W=112, and a function psum_lane(bus, k, j) that returns the 14b lane.
- Core must use the same constants.
- One sub-module, psum_sum9: for one channel, sign-extends 9 PSUM_W inputs and produces the registered 18b sum. Instantiated N_CH times.
- Delay lines, accumulator and output stage live in the top module.

Test Plan:
1. Slices 0..8, all channels = 10 for cycles T..T+2; single pulse with in_first=in_last=1, shift_amt=0 -> out_valid at T+4, every channel 90.
2. Skew check: column-0 slices = 1 only at T, column-1 = 2 only at T+1, column-2 = 4 only at T+2, otherwise 0; first=last=1 -> every channel 3*(1+2+4)=21. Any misalignment gives a different value.
3. All lanes = -5 (0x3FFB), first=last=1 -> sum -45, out_data=0. All lanes = 8191, shift 0 -> 255 (saturated).
4. Four back-to-back vectors, all lanes 100, first on vector 0, last on vector 3, shift_amt=4 -> acc 3600, single out_valid 4 cycles after vector 3, out_data 225 per channel.
5. out_ready=0, two single-tile results (values 10 then 20) -> out_data=20, ovf_flag=1, out_valid held. out_ready=1 for one cycle -> out_valid=0.
6. rst=1 at T+2 of an in-flight vector -> no out_valid, busy=0; the next single-tile vector (lanes 10) outputs 90, showing the accumulator was cleared.
